l1_mem_arbiter: RTL

Shares one line-granular memory port between the instruction-cache and data-cache L1 controllers. Each L1 presents an `l1cache_mem_if` Client; the arbiter acts as their Server and as a single Client toward the memory side. It arbitrates round-robin and rewrites request IDs through a 4-entry tag table. Responses may return out of order and are routed back by downstream ID with the original client ID restored.

---
 rtl/l1cache_mem_if.sv | 24 ++
 rtl/l1_mem_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/l1cache_mem_if.sv
// rtl/l1cache_mem_if.sv - line-granular L1 <-> memory request/response channel pair
// Client issues requests and sinks responses; Server is the opposite side.
interface l1cache_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_id;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [1:0]  resp_id;

  modport Client (
    output req_valid, req_we, req_addr, req_data, req_id, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport Server (
    input  req_valid, req_we, req_addr, req_data, req_id, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - round-robin icache/dcache arbiter onto one memory port
// Downstream IDs index a 4-entry tag table that restores client and original ID on response.
module l1_mem_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  l1cache_mem_if.Server icache,
  l1cache_mem_if.Server dcache,
  l1cache_mem_if.Client mem,
  output logic          err
);

  logic [3:0]      vld_q, vld_d;
  logic [3:0]      client_q, client_d;
  logic [3:0][1:0] orig_q, orig_d;
  logic            lock_vld_q, lock_vld_d;
  logic            lock_client_q, lock_client_d;
  logic [1:0]      lock_id_q, lock_id_d;
  logic            rr_last_q, rr_last_d;
  logic            err_q, err_d;

  logic            any_free;
  logic [1:0]      free_id;
  logic            gnt_vld;
  logic            gnt_client;
  logic [1:0]      gnt_id;
  logic            sel_valid;
  logic            sel_we;
  logic [31:0]     sel_addr;
  logic [63:0]     sel_data;
  logic [1:0]      sel_id;
  logic            req_hs;
  logic [1:0]      rsp_idx;
  logic            rsp_hit;
  logic            rsp_tgt;
  logic            rsp_ready;
  logic            rsp_hs;

  // Lowest free entry; the descending loop lets the smallest index win.
  always_comb begin
    free_id  = 2'd0;
    any_free = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_id  = 2'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_vld    = 1'b0;
    gnt_client = 1'b0;
    gnt_id     = free_id;
    if (lock_vld_q) begin
      gnt_vld    = 1'b1;
      gnt_client = lock_client_q;
      gnt_id     = lock_id_q;
    end else if (any_free) begin
      if (icache.req_valid && dcache.req_valid) begin
        gnt_vld    = 1'b1;
        gnt_client = ~rr_last_q;
      end else if (icache.req_valid) begin
        gnt_vld    = 1'b1;
        gnt_client = 1'b0;
      end else if (dcache.req_valid) begin
        gnt_vld    = 1'b1;
        gnt_client = 1'b1;
      end
    end
  end

  assign sel_valid = gnt_client ? dcache.req_valid : icache.req_valid;
  assign sel_we    = gnt_client ? dcache.req_we    : icache.req_we;
  assign sel_addr  = gnt_client ? dcache.req_addr  : icache.req_addr;
  assign sel_data  = gnt_client ? dcache.req_data  : icache.req_data;
  assign sel_id    = gnt_client ? dcache.req_id    : icache.req_id;

  // Handshakes exclude rst_n so the reset net only gates outputs, never flop data.
  assign req_hs = gnt_vld & sel_valid & mem.req_ready;

  assign mem.req_valid    = rst_n & gnt_vld & sel_valid;
  assign mem.req_we       = sel_we;
  assign mem.req_addr     = sel_addr;
  assign mem.req_data     = sel_data;
  assign mem.req_id       = gnt_id;
  assign icache.req_ready = rst_n & gnt_vld & ~gnt_client & mem.req_ready;
  assign dcache.req_ready = rst_n & gnt_vld &  gnt_client & mem.req_ready;

  assign rsp_idx   = mem.resp_id;
  assign rsp_hit   = vld_q[rsp_idx];
  assign rsp_tgt   = client_q[rsp_idx];
  // Beats with an unallocated ID are always accepted so a stray response cannot wedge memory.
  assign rsp_ready = rsp_hit ? (rsp_tgt ? dcache.resp_ready : icache.resp_ready) : 1'b1;
  assign rsp_hs    = mem.resp_valid & rsp_ready & rsp_hit;

  assign mem.resp_ready    = rst_n & rsp_ready;
  assign icache.resp_valid = rst_n & mem.resp_valid & rsp_hit & ~rsp_tgt;
  assign dcache.resp_valid = rst_n & mem.resp_valid & rsp_hit &  rsp_tgt;
  assign icache.resp_data  = mem.resp_data;
  assign dcache.resp_data  = mem.resp_data;
  assign icache.resp_id    = orig_q[rsp_idx];
  assign dcache.resp_id    = orig_q[rsp_idx];

  assign err = err_q;

  always_comb begin
    vld_d         = vld_q;
    client_d      = client_q;
    orig_d        = orig_q;
    lock_vld_d    = lock_vld_q;
    lock_client_d = lock_client_q;
    lock_id_d     = lock_id_q;
    rr_last_d     = rr_last_q;
    err_d         = err_q;

    if (rsp_hs) begin
      vld_d[rsp_idx] = 1'b0;
    end

    // Allocation targets a free entry and the free targets a valid one, so they never collide.
    if (req_hs) begin
      vld_d[gnt_id]    = 1'b1;
      client_d[gnt_id] = gnt_client;
      orig_d[gnt_id]   = sel_id;
      rr_last_d        = gnt_client;
      lock_vld_d       = 1'b0;
    end else if (gnt_vld && sel_valid) begin
      lock_vld_d    = 1'b1;
      lock_client_d = gnt_client;
      lock_id_d     = gnt_id;
    end

    if (mem.resp_valid && !rsp_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q         <= '0;
      client_q      <= '0;
      orig_q        <= '0;
      lock_vld_q    <= 1'b0;
      lock_client_q <= 1'b0;
      lock_id_q     <= 2'd0;
      rr_last_q     <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      client_q      <= client_d;
      orig_q        <= orig_d;
      lock_vld_q    <= lock_vld_d;
      lock_client_q <= lock_client_d;
      lock_id_q     <= lock_id_d;
      rr_last_q     <= rr_last_d;
      err_q         <= err_d;
    end
  end

endmodule
